// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices and
// the CAUSE register layout.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQC_PEND  = 2'd0;
  localparam logic [1:0] IRQC_MASK  = 2'd1;
  localparam logic [1:0] IRQC_EDGE  = 2'd2;
  localparam logic [1:0] IRQC_CAUSE = 2'd3;

  localparam int CAUSE_VALID_BIT = 15;
  localparam int CAUSE_INSVC_LSB = 10;
  localparam int CAUSE_IDX_W     = 4;

  function automatic logic [15:0] pack_cause(input logic                   cvalid,
                                             input logic [4:0]             insvc,
                                             input logic [CAUSE_IDX_W-1:0] cause);
    logic [15:0] r;
    r                            = 16'h0000;
    r[CAUSE_VALID_BIT]           = cvalid;
    r[CAUSE_INSVC_LSB +: 5]      = insvc;
    r[CAUSE_IDX_W-1:0]           = cause;
    return r;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for one asynchronous interrupt source, with a
// rising-edge detector on the synchronised value.
module irq_sync
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic s_o,
  output logic e_o
);

  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_d;
  logic            prev_q;
  logic            prev_d;

  // Shift the raw source into the chain; prev tracks the synchronised output.
  always_comb begin
    sync_d = {sync_q[SYNC-2:0], src_i};
    prev_d = sync_q[SYNC-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s_o = sync_q[SYNC-1];
  assign e_o = sync_q[SYNC-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level pending bits, mask, fixed
// priority (index 0 highest), registered irq and a 4-word MMIO window.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int SYNC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            irq_ack,
  input  logic [1:0]      addr,
  input  logic            rd_en,
  input  logic            wr_en,
  input  logic [15:0]     wdata,
  output logic [15:0]     rdata
);

  logic [NSRC-1:0] s_s;
  logic [NSRC-1:0] e_s;
  logic [NSRC-1:0] act_s;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] ack_clr_s;
  logic            cvalid_s;
  logic [3:0]      cause_s;

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [4:0]      insvc_q, insvc_d;
  logic            irq_q, irq_d;
  logic [15:0]     rdata_q, rdata_d;

  logic            unused_wdata_s;
  assign unused_wdata_s = ^wdata[15:NSRC];

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_sync
      irq_sync #(.SYNC(SYNC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .src_i (src[g]),
        .s_o   (s_s[g]),
        .e_o   (e_s[g])
      );
    end
  endgenerate

  // Fixed-priority encoder: scanning high to low leaves the lowest active index.
  always_comb begin
    act_s    = pend_q & mask_q;
    cvalid_s = |act_s;
    cause_s  = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      cause_s = act_s[i] ? i[3:0] : cause_s;
    end
  end

  // Pending, mask, mode and in-service next state.
  always_comb begin
    w1c_s     = {NSRC{1'b0}};
    ack_clr_s = {NSRC{1'b0}};
    mask_d    = mask_q;
    edge_d    = edge_q;
    insvc_d   = insvc_q;
    irq_d     = cvalid_s;
    if (wr_en && (addr == IRQC_PEND)) begin
      w1c_s = wdata[NSRC-1:0];
    end else begin
      w1c_s = {NSRC{1'b0}};
    end
    if (wr_en && (addr == IRQC_MASK)) begin
      mask_d = wdata[NSRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_en && (addr == IRQC_EDGE)) begin
      edge_d = wdata[NSRC-1:0];
    end else begin
      edge_d = edge_q;
    end
    for (int i = 0; i < NSRC; i++) begin
      ack_clr_s[i] = irq_ack & cvalid_s & (cause_s == i[3:0]);
    end
    if (irq_ack) begin
      insvc_d = cvalid_s ? {1'b1, cause_s} : 5'b0_0000;
    end else begin
      insvc_d = insvc_q;
    end
    // A fresh edge always wins over W1C or ack so a re-trigger is never lost.
    pend_d = (edge_q & (e_s | (pend_q & ~w1c_s & ~ack_clr_s)))
           | (~edge_q & s_s);
  end

  // Read mux samples pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        IRQC_PEND:  rdata_d = {{(16-NSRC){1'b0}}, pend_q};
        IRQC_MASK:  rdata_d = {{(16-NSRC){1'b0}}, mask_q};
        IRQC_EDGE:  rdata_d = {{(16-NSRC){1'b0}}, edge_q};
        IRQC_CAUSE: rdata_d = pack_cause(cvalid_s, insvc_q, cause_s);
        default:    rdata_d = 16'h0000;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= {NSRC{1'b0}};
      mask_q  <= {NSRC{1'b0}};
      edge_q  <= {NSRC{1'b0}};
      insvc_q <= 5'b0_0000;
      irq_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      insvc_q <= insvc_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign irq   = irq_q;
  assign rdata = rdata_q;

endmodule
